// File: rtl/dcache_ctrl.sv
// Direct-mapped write-through, no-write-allocate L1 D-cache controller; one core request in flight.
// Load hit: 1 cycle to response. Misses and all stores take a memory round trip. Request and response outputs hold until handshaked.
module dcache_ctrl #(
    parameter  int NUM_LINES = 16,
    localparam int INDEX_W   = $clog2(NUM_LINES),
    localparam int TAG_W     = 28 - INDEX_W
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    input  logic          flush_i,
    input  logic          core_req_valid_i,
    output logic          core_req_ready_o,
    input  logic [31:0]   core_addr_i,
    input  logic          core_we_i,
    input  logic [31:0]   core_wdata_i,
    output logic          core_rsp_valid_o,
    input  logic          core_rsp_ready_i,
    output logic [31:0]   core_rsp_data_o,
    output logic          mem_req_valid_o,
    input  logic          mem_req_ready_i,
    output logic [31:0]   mem_addr_o,
    output logic          mem_we_o,
    output logic [31:0]   mem_wdata_o,
    input  logic          mem_rsp_valid_i,
    output logic          mem_rsp_ready_o,
    input  logic [31:0]   mem_rsp_addr_i,
    input  logic [127:0]  mem_rsp_line_i
);

    typedef enum logic [1:0] {IDLE, MREQ, MWAIT, RESP} state_e;

    state_e               state_q, state_d;
    logic [31:2]          addr_q, addr_d;
    logic                 we_q, we_d;
    logic [31:0]          wdata_q, wdata_d;
    logic [31:0]          rsp_data_q, rsp_data_d;
    logic [NUM_LINES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]     tag_q [NUM_LINES];
    logic [127:0]         data_q [NUM_LINES];

    logic [INDEX_W-1:0]   req_idx, lat_idx;
    logic [TAG_W-1:0]     req_tag;
    logic [1:0]           req_word, lat_word;
    logic                 hit, fill_en, st_upd_en;
    logic                 unused_addr_bits;

    assign req_idx  = core_addr_i[4 +: INDEX_W];
    assign req_tag  = core_addr_i[31 -: TAG_W];
    assign req_word = core_addr_i[3:2];
    assign lat_idx  = addr_q[4 +: INDEX_W];
    assign lat_word = addr_q[3:2];
    assign hit      = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign unused_addr_bits = ^core_addr_i[1:0];

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        rsp_data_d = rsp_data_q;
        valid_d    = valid_q;
        fill_en    = 1'b0;
        st_upd_en  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (flush_i) begin
                    valid_d = '0;
                end else if (core_req_valid_i) begin
                    addr_d  = core_addr_i[31:2];
                    we_d    = core_we_i;
                    wdata_d = core_wdata_i;
                    if (core_we_i) begin
                        // Store hits patch the line now; the write still goes to memory.
                        st_upd_en  = hit;
                        rsp_data_d = '0;
                        state_d    = MREQ;
                    end else if (hit) begin
                        rsp_data_d = data_q[req_idx][{req_word, 5'b0} +: 32];
                        state_d    = RESP;
                    end else begin
                        state_d = MREQ;
                    end
                end
            end
            MREQ: if (mem_req_ready_i) state_d = MWAIT;
            MWAIT: begin
                // Responses for other lines are consumed and ignored.
                if (mem_rsp_valid_i && (mem_rsp_addr_i == {addr_q[31:4], 4'h0})) begin
                    if (!we_q) begin
                        fill_en          = 1'b1;
                        valid_d[lat_idx] = 1'b1;
                        rsp_data_d       = mem_rsp_line_i[{lat_word, 5'b0} +: 32];
                    end else begin
                        rsp_data_d = '0;
                    end
                    state_d = RESP;
                end
            end
            RESP: if (core_rsp_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            rsp_data_q <= '0;
            valid_q    <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            rsp_data_q <= rsp_data_d;
            valid_q    <= valid_d;
        end
    end

    // Tag and data contents are qualified by valid_q, so they need no reset.
    always_ff @(posedge clk_i) begin
        if (fill_en) begin
            data_q[lat_idx] <= mem_rsp_line_i;
            tag_q[lat_idx]  <= addr_q[31 -: TAG_W];
        end else if (st_upd_en) begin
            data_q[req_idx][{req_word, 5'b0} +: 32] <= core_wdata_i;
        end
    end

    assign core_req_ready_o = (state_q == IDLE) && !flush_i;
    assign core_rsp_valid_o = (state_q == RESP);
    assign core_rsp_data_o  = rsp_data_q;
    assign mem_req_valid_o  = (state_q == MREQ);
    assign mem_rsp_ready_o  = (state_q == MWAIT);
    assign mem_we_o         = (state_q == MREQ) && we_q;
    assign mem_wdata_o      = mem_we_o ? wdata_q : 32'h0;
    assign mem_addr_o       = (state_q != MREQ) ? 32'h0 :
                              we_q ? {addr_q[31:2], 2'b00} : {addr_q[31:4], 4'h0};

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl with a reactive word-equals-address memory model.
module tb_dcache_ctrl;
    logic         clk_i = 1'b0;
    logic         rstn_i, flush_i;
    logic         core_req_valid_i, core_req_ready_o, core_we_i;
    logic [31:0]  core_addr_i, core_wdata_i, core_rsp_data_o;
    logic         core_rsp_valid_o, core_rsp_ready_i;
    logic         mem_req_valid_o, mem_req_ready_i, mem_we_o;
    logic [31:0]  mem_addr_o, mem_wdata_o, mem_rsp_addr_i;
    logic         mem_rsp_valid_i, mem_rsp_ready_o;
    logic [127:0] mem_rsp_line_i;

    int total = 0;
    int bad   = 0;

    // memory model state
    logic [31:0] mem [logic [31:0]];
    int          req_cnt = 0;
    int          req_stall = 0;
    bit          inject_bad = 0;
    bit          pend = 0;
    logic [31:0] pend_addr, last_addr, last_wdata;
    logic        last_we;

    always #5 clk_i = ~clk_i;

    dcache_ctrl #(.NUM_LINES(16)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .flush_i(flush_i),
        .core_req_valid_i(core_req_valid_i), .core_req_ready_o(core_req_ready_o),
        .core_addr_i(core_addr_i), .core_we_i(core_we_i), .core_wdata_i(core_wdata_i),
        .core_rsp_valid_o(core_rsp_valid_o), .core_rsp_ready_i(core_rsp_ready_i),
        .core_rsp_data_o(core_rsp_data_o),
        .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
        .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o), .mem_wdata_o(mem_wdata_o),
        .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rsp_ready_o(mem_rsp_ready_o),
        .mem_rsp_addr_i(mem_rsp_addr_i), .mem_rsp_line_i(mem_rsp_line_i)
    );

    function automatic logic [31:0] rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : a;
    endfunction

    // Memory responder: accepts a request one cycle after it appears (unless stalled),
    // then returns the line the cycle after MWAIT is entered.
    initial begin
        mem_req_ready_i = 1'b0;
        mem_rsp_valid_i = 1'b0;
        mem_rsp_addr_i  = '0;
        mem_rsp_line_i  = '0;
        forever begin
            @(negedge clk_i);
            mem_req_ready_i = 1'b0;
            mem_rsp_valid_i = 1'b0;
            if (!rstn_i) begin
                pend = 0;
            end else if (mem_req_valid_o) begin
                if (req_stall > 0) begin
                    req_stall--;
                end else begin
                    mem_req_ready_i = 1'b1;
                    req_cnt++;
                    last_addr  = mem_addr_o;
                    last_we    = mem_we_o;
                    last_wdata = mem_wdata_o;
                    if (mem_we_o) mem[mem_addr_o] = mem_wdata_o;
                    pend      = 1;
                    pend_addr = {mem_addr_o[31:4], 4'h0};
                end
            end else if (mem_rsp_ready_o && pend) begin
                mem_rsp_valid_i = 1'b1;
                if (inject_bad) begin
                    inject_bad      = 0;
                    mem_rsp_addr_i  = pend_addr ^ 32'h100;
                    mem_rsp_line_i  = {4{32'hBAD0_BAD0}};
                end else begin
                    pend           = 0;
                    mem_rsp_addr_i = pend_addr;
                    mem_rsp_line_i = {rd(pend_addr + 12), rd(pend_addr + 8),
                                      rd(pend_addr + 4), rd(pend_addr)};
                end
            end
        end
    end

    task automatic start_req(input logic [31:0] a, input logic we, input logic [31:0] wd);
        int n = 0;
        @(negedge clk_i);
        core_req_valid_i = 1'b1;
        core_addr_i      = a;
        core_we_i        = we;
        core_wdata_i     = wd;
        while (!core_req_ready_o && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        @(negedge clk_i);
        core_req_valid_i = 1'b0;
    endtask

    task automatic finish_rsp(input int hold, output logic [31:0] d, output int lat,
                              output bit stable, output bit tmo);
        lat = 1;
        tmo = 0;
        while (!core_rsp_valid_o && lat < 200) begin
            @(negedge clk_i);
            lat++;
        end
        if (!core_rsp_valid_o) tmo = 1;
        d      = core_rsp_data_o;
        stable = 1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk_i);
            if (!core_rsp_valid_o || core_rsp_data_o !== d) stable = 0;
        end
        core_rsp_ready_i = 1'b1;
        @(negedge clk_i);
        core_rsp_ready_i = 1'b0;
    endtask

    task automatic do_req(input logic [31:0] a, input logic we, input logic [31:0] wd,
                          output logic [31:0] d, output int lat, output bit tmo);
        bit st;
        start_req(a, we, wd);
        finish_rsp(0, d, lat, st, tmo);
    endtask

    task automatic test_reset;
        total++; if (core_req_ready_o !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%b want=1", core_req_ready_o); end
        total++; if (core_rsp_valid_o !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b want=0", core_rsp_valid_o); end
        total++; if (mem_req_valid_o !== 1'b0 || mem_rsp_ready_o !== 1'b0) begin bad++; $display("FAIL reset_mem_hs got=%b%b want=00", mem_req_valid_o, mem_rsp_ready_o); end
        total++; if (core_rsp_data_o !== 32'h0 || mem_addr_o !== 32'h0 || mem_wdata_o !== 32'h0 || mem_we_o !== 1'b0) begin
            bad++; $display("FAIL reset_data got=%h/%h/%h/%b want=0", core_rsp_data_o, mem_addr_o, mem_wdata_o, mem_we_o);
        end
    endtask

    task automatic test_cold_load;
        logic [31:0] d; int lat; bit tmo; int c0 = req_cnt;
        do_req(32'h0000_1234, 1'b0, 32'h0, d, lat, tmo);
        total++; if (tmo !== 1'b0) begin bad++; $display("FAIL cold_timeout got=%0d want=0", tmo); end
        total++; if (req_cnt - c0 !== 1) begin bad++; $display("FAIL cold_reqs got=%0d want=1", req_cnt - c0); end
        total++; if (last_addr !== 32'h0000_1230 || last_we !== 1'b0) begin bad++; $display("FAIL cold_mem_req got=%h/%b want=00001230/0", last_addr, last_we); end
        total++; if (d !== 32'h0000_1234) begin bad++; $display("FAIL cold_data got=%h want=00001234", d); end
        total++; if (dut.valid_q[3] !== 1'b1) begin bad++; $display("FAIL cold_line3_valid got=%b want=1", dut.valid_q[3]); end
    endtask

    task automatic test_hit;
        logic [31:0] d; int lat; bit tmo; int c0 = req_cnt;
        do_req(32'h0000_1238, 1'b0, 32'h0, d, lat, tmo);
        total++; if (req_cnt - c0 !== 0) begin bad++; $display("FAIL hit_reqs got=%0d want=0", req_cnt - c0); end
        total++; if (d !== 32'h0000_1238) begin bad++; $display("FAIL hit_data got=%h want=00001238", d); end
        total++; if (lat !== 1) begin bad++; $display("FAIL hit_latency got=%0d want=1", lat); end
    endtask

    task automatic test_store_hit;
        logic [31:0] d; int lat; bit tmo; int c0 = req_cnt;
        do_req(32'h0000_1234, 1'b1, 32'hDEAD_BEEF, d, lat, tmo);
        total++; if (req_cnt - c0 !== 1) begin bad++; $display("FAIL st_reqs got=%0d want=1", req_cnt - c0); end
        total++; if (last_addr !== 32'h0000_1234 || last_we !== 1'b1 || last_wdata !== 32'hDEAD_BEEF) begin
            bad++; $display("FAIL st_mem_req got=%h/%b/%h want=00001234/1/deadbeef", last_addr, last_we, last_wdata);
        end
        total++; if (d !== 32'h0) begin bad++; $display("FAIL st_rsp_data got=%h want=0", d); end
        c0 = req_cnt;
        do_req(32'h0000_1234, 1'b0, 32'h0, d, lat, tmo);
        total++; if (d !== 32'hDEAD_BEEF || req_cnt - c0 !== 0 || lat !== 1) begin
            bad++; $display("FAIL st_then_hit got=%h/%0d/%0d want=deadbeef/0/1", d, req_cnt - c0, lat);
        end
    endtask

    task automatic test_conflict;
        logic [31:0] d; int lat; bit tmo; int c0 = req_cnt;
        do_req(32'h0000_1334, 1'b0, 32'h0, d, lat, tmo);
        total++; if (req_cnt - c0 !== 1 || d !== 32'h0000_1334) begin bad++; $display("FAIL conflict_miss got=%0d/%h want=1/00001334", req_cnt - c0, d); end
        c0 = req_cnt;
        do_req(32'h0000_1234, 1'b0, 32'h0, d, lat, tmo);
        total++; if (req_cnt - c0 !== 1 || d !== 32'hDEAD_BEEF) begin bad++; $display("FAIL conflict_refill got=%0d/%h want=1/deadbeef", req_cnt - c0, d); end
    endtask

    task automatic test_store_miss;
        logic [31:0] d; int lat; bit tmo; int c0 = req_cnt;
        do_req(32'h0000_2000, 1'b1, 32'h55AA_33CC, d, lat, tmo);
        total++; if (req_cnt - c0 !== 1 || last_we !== 1'b1 || last_addr !== 32'h0000_2000) begin
            bad++; $display("FAIL stmiss_req got=%0d/%b/%h want=1/1/00002000", req_cnt - c0, last_we, last_addr);
        end
        c0 = req_cnt;
        do_req(32'h0000_2000, 1'b0, 32'h0, d, lat, tmo);
        total++; if (req_cnt - c0 !== 1 || last_we !== 1'b0 || d !== 32'h55AA_33CC) begin
            bad++; $display("FAIL stmiss_noalloc got=%0d/%b/%h want=1/0/55aa33cc", req_cnt - c0, last_we, d);
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] d; int lat; bit st, tmo, req_stable; int c0 = req_cnt;
        req_stall  = 3;
        req_stable = 1;
        start_req(32'h0000_3008, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            if (!mem_req_valid_o || mem_addr_o !== 32'h0000_3000 || mem_we_o !== 1'b0) req_stable = 0;
            @(negedge clk_i);
        end
        total++; if (req_stable !== 1'b1) begin bad++; $display("FAIL bp_req_stable got=%b want=1", req_stable); end
        finish_rsp(2, d, lat, st, tmo);
        total++; if (st !== 1'b1 || tmo !== 1'b0) begin bad++; $display("FAIL bp_rsp_stable got=%b/%b want=1/0", st, tmo); end
        total++; if (d !== 32'h0000_3008 || req_cnt - c0 !== 1) begin bad++; $display("FAIL bp_data got=%h/%0d want=00003008/1", d, req_cnt - c0); end
    endtask

    task automatic test_bad_rsp;
        logic [31:0] d; int lat; bit tmo; int c0;
        inject_bad = 1;
        do_req(32'h0000_4010, 1'b0, 32'h0, d, lat, tmo);
        total++; if (d !== 32'h0000_4010 || tmo !== 1'b0) begin bad++; $display("FAIL badrsp_data got=%h/%b want=00004010/0", d, tmo); end
        c0 = req_cnt;
        do_req(32'h0000_4014, 1'b0, 32'h0, d, lat, tmo);
        total++; if (d !== 32'h0000_4014 || req_cnt - c0 !== 0) begin bad++; $display("FAIL badrsp_hit got=%h/%0d want=00004014/0", d, req_cnt - c0); end
    endtask

    task automatic test_flush;
        logic [31:0] d; int lat; bit tmo; int c0 = req_cnt;
        do_req(32'h0000_1238, 1'b0, 32'h0, d, lat, tmo);
        total++; if (req_cnt - c0 !== 0) begin bad++; $display("FAIL flush_prehit got=%0d want=0", req_cnt - c0); end
        @(negedge clk_i);
        flush_i = 1'b1;
        #1;
        total++; if (core_req_ready_o !== 1'b0) begin bad++; $display("FAIL flush_ready got=%b want=0", core_req_ready_o); end
        @(negedge clk_i);
        flush_i = 1'b0;
        c0 = req_cnt;
        do_req(32'h0000_1238, 1'b0, 32'h0, d, lat, tmo);
        total++; if (req_cnt - c0 !== 1 || d !== 32'h0000_1238) begin bad++; $display("FAIL flush_miss got=%0d/%h want=1/00001238", req_cnt - c0, d); end
    endtask

    initial begin
        rstn_i           = 1'b0;
        flush_i          = 1'b0;
        core_req_valid_i = 1'b0;
        core_addr_i      = '0;
        core_we_i        = 1'b0;
        core_wdata_i     = '0;
        core_rsp_ready_i = 1'b0;
        repeat (3) @(negedge clk_i);
        rstn_i = 1'b1;
        @(negedge clk_i);
        test_reset();
        test_cold_load();
        test_hit();
        test_store_hit();
        test_conflict();
        test_store_miss();
        test_backpressure();
        test_bad_rsp();
        test_flush();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
